frame_pixel_server: RTL and testbench



---
 rtl/frame_pixel_server.sv | 152 +++++++++++++++
 tb/tb_frame_pixel_server.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_server.sv
// rtl/frame_pixel_server.sv - 160x120x8 framebuffer pixel server for a 640x480 VGA driver
module frame_pixel_server #(
    parameter int         FB_W        = 160,
    parameter int         FB_H        = 120,
    parameter int         SCALE_SHIFT = 2,
    parameter logic [7:0] CLEAR_COLOR = 8'h00,
    parameter logic [7:0] OOB_COLOR   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    output logic [7:0] color_out,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [7:0] wr_color,
    output logic       wr_err,
    input  logic       clear_req,
    output logic       busy,
    output logic       clear_done,
    output logic       frame_tick
);
    localparam int          FB_SIZE   = FB_W * FB_H;
    localparam logic [14:0] LAST_ADDR = 15'(FB_SIZE - 1);
    localparam logic [7:0]  FB_W_L    = 8'(FB_W);
    localparam logic [6:0]  FB_H_L    = 7'(FB_H);
    localparam logic [9:0]  SCR_W     = 10'(FB_W << SCALE_SHIFT);
    localparam logic [9:0]  SCR_H     = 10'(FB_H << SCALE_SHIFT);

    typedef enum logic [1:0] {CLEAR_INIT, CLEAR, IDLE} state_t;

    state_t      state;
    logic [14:0] clr_addr;
    logic [7:0]  ram [0:FB_SIZE-1];

    // Row stride of 160 built from shifts: y*128 + y*32 + x
    function automatic logic [14:0] addr_of(input logic [7:0] x, input logic [6:0] y);
        addr_of = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    endfunction

    logic        wr_fire;
    logic        wr_in_range;
    logic [14:0] wr_addr;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < FB_W_L) && (wr_y < FB_H_L);
    assign wr_addr     = addr_of(wr_x, wr_y);

    logic        ram_we;
    logic [14:0] ram_waddr;
    logic [7:0]  ram_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = CLEAR_COLOR;
        if (state == CLEAR) begin
            ram_we = !rst;
        end else if (wr_fire && wr_in_range) begin
            ram_we    = !rst;
            ram_waddr = wr_addr;
            ram_wdata = wr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR_INIT;
            clr_addr   <= '0;
            busy       <= 1'b0;
            wr_ready   <= 1'b0;
            clear_done <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            if (wr_fire && !wr_in_range)
                wr_err <= 1'b1;
            case (state)
                CLEAR_INIT: begin
                    state    <= CLEAR;
                    busy     <= 1'b1;
                    clr_addr <= '0;
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        wr_ready   <= 1'b1;
                        clear_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                IDLE: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    state    <= CLEAR_INIT;
                    busy     <= 1'b0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic        req_in;
    logic [9:0]  prev_x;
    logic [9:0]  prev_y;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic [14:0] rd_idx;

    assign fx     = 8'(req_x >> SCALE_SHIFT);
    assign fy     = 7'(req_y >> SCALE_SHIFT);
    // Out-of-screen requests park the read on address 0; the data is discarded
    assign rd_idx = req_in ? addr_of(fx, fy) : 15'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_x      <= '0;
            req_y      <= '0;
            req_in     <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            color_out  <= '0;
            frame_tick <= 1'b0;
        end else begin
            req_x      <= next_x;
            req_y      <= next_y;
            req_in     <= (next_x < SCR_W) && (next_y < SCR_H);
            color_out  <= req_in ? ram[rd_idx] : OOB_COLOR;
            frame_tick <= (req_x == 10'd0) && (req_y == 10'd0) &&
                          ((prev_x != 10'd0) || (prev_y != 10'd0));
            prev_x     <= req_x;
            prev_y     <= req_y;
        end
    end
endmodule

// File: tb/tb_frame_pixel_server.sv
// tb/tb_frame_pixel_server.sv - scoreboard bench for frame_pixel_server
module tb_frame_pixel_server;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] next_x = '0;
    logic [9:0] next_y = '0;
    logic [7:0] color_out;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_x = '0;
    logic [6:0] wr_y = '0;
    logic [7:0] wr_color = '0;
    logic       wr_err;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       clear_done;
    logic       frame_tick;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         tag_q[$];
    int         tick_q[$];

    logic [9:0] rd_x [0:15];
    logic [9:0] rd_y [0:15];
    logic [7:0] rd_e [0:15];

    frame_pixel_server dut (
        .clk(clk), .rst(rst), .next_x(next_x), .next_y(next_y), .color_out(color_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .wr_err(wr_err), .clear_req(clear_req), .busy(busy),
        .clear_done(clear_done), .frame_tick(frame_tick)
    );

    always #10 clk = ~clk;

    task automatic set_rd(input int i, input int x, input int y, input logic [7:0] e);
        rd_x[i] = 10'(x);
        rd_y[i] = 10'(y);
        rd_e[i] = e;
    endtask

    // Pipelined requests, one per cycle; expected colours queued on issue, popped two cycles later
    task automatic read_stream(input int n, input string name);
        logic [7:0] e;
        int         t;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if (color_out !== e) begin
                    bad++;
                    $display("FAIL %s req%0d color_out=%h expected=%h", name, t, color_out, e);
                end
            end
            if (i < n) begin
                next_x = rd_x[i];
                next_y = rd_y[i];
                exp_q.push_back(rd_e[i]);
                tag_q.push_back(i);
            end
        end
    endtask

    task automatic do_write(input int x, input int y, input logic [7:0] c, output logic rdy_now);
        int guard;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_x     = 8'(x);
        wr_y     = 7'(y);
        wr_color = c;
        rdy_now  = wr_ready;
        guard    = 0;
        while (!wr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!wr_ready) begin
            total++;
            bad++;
            $display("FAIL write_timeout wr_ready=%b expected=1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Counts busy samples from the next negedge until busy falls
    task automatic count_clear(output int cycles, output int dones, output int ticks,
                               output logic rdy_end, output logic done_end);
        cycles   = 0;
        dones    = 0;
        ticks    = 0;
        rdy_end  = 1'b0;
        done_end = 1'b0;
        for (int g = 0; g < 20000; g++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (clear_done) dones++;
            if (frame_tick) ticks++;
            if (busy) begin
                cycles++;
            end else if (cycles > 0) begin
                rdy_end  = wr_ready;
                done_end = clear_done;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int cyc, dn, tk;
        logic re, de;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({color_out, wr_ready, wr_err, busy, clear_done, frame_tick} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {color_out, wr_ready, wr_err, busy, clear_done, frame_tick});
        end
        rst = 1'b0;
        count_clear(cyc, dn, tk, re, de);
        total++;
        if (cyc !== 19200) begin bad++; $display("FAIL init_clear_len got=%0d expected=19200", cyc); end
        total++;
        if (dn !== 1) begin bad++; $display("FAIL init_clear_done got=%0d expected=1", dn); end
        total++;
        if (re !== 1'b1 || de !== 1'b1) begin
            bad++;
            $display("FAIL init_ready_done got=%b%b expected=11", re, de);
        end
        set_rd(0, 0, 0, 8'h00);
        set_rd(1, 320, 240, 8'h00);
        set_rd(2, 639, 479, 8'h00);
        read_stream(3, "post_clear_read");
    endtask

    task automatic test_write_read;
        logic r;
        do_write(10, 20, 8'hE0, r);
        set_rd(0, 40, 80, 8'hE0);
        set_rd(1, 41, 81, 8'hE0);
        set_rd(2, 42, 82, 8'hE0);
        set_rd(3, 43, 83, 8'hE0);
        set_rd(4, 40, 83, 8'hE0);
        set_rd(5, 43, 80, 8'hE0);
        set_rd(6, 44, 80, 8'h00);
        set_rd(7, 39, 80, 8'h00);
        set_rd(8, 40, 84, 8'h00);
        read_stream(9, "upscale_read");
    endtask

    task automatic test_corners;
        logic r;
        do_write(159, 119, 8'h1C, r);
        do_write(0, 0, 8'h03, r);
        set_rd(0, 639, 479, 8'h1C);
        set_rd(1, 0, 0, 8'h03);
        set_rd(2, 636, 476, 8'h1C);
        set_rd(3, 3, 3, 8'h03);
        set_rd(4, 640, 0, 8'h00);
        set_rd(5, 0, 480, 8'h00);
        set_rd(6, 1023, 1023, 8'h00);
        read_stream(7, "corner_read");
        total++;
        if (wr_err !== 1'b0) begin bad++; $display("FAIL corner_wr_err got=%b expected=0", wr_err); end
    endtask

    task automatic test_bad_write;
        logic r;
        do_write(160, 0, 8'hFF, r);
        total++;
        if (r !== 1'b1) begin bad++; $display("FAIL oob_x_ready got=%b expected=1", r); end
        total++;
        if (wr_err !== 1'b1) begin bad++; $display("FAIL oob_x_err got=%b expected=1", wr_err); end
        do_write(0, 120, 8'hFF, r);
        do_write(9, 9, 8'h11, r);
        total++;
        if (wr_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b expected=1", wr_err); end
        set_rd(0, 0, 4, 8'h00);
        set_rd(1, 639, 479, 8'h1C);
        set_rd(2, 0, 0, 8'h03);
        set_rd(3, 40, 80, 8'hE0);
        set_rd(4, 36, 36, 8'h11);
        read_stream(5, "oob_write_read");
    endtask

    task automatic test_clear_with_write;
        int cyc, dn, tk;
        logic re, de;
        @(negedge clk);
        wr_valid  = 1'b1;
        wr_x      = 8'd5;
        wr_y      = 7'd5;
        wr_color  = 8'hAA;
        clear_req = 1'b1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL clr_wr_accept got=%b expected=1", wr_ready); end
        @(negedge clk);
        clear_req = 1'b0;
        total++;
        if (busy !== 1'b1 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_start busy_ready=%b%b expected=10", busy, wr_ready);
        end
        wr_x     = 8'd6;
        wr_y     = 7'd6;
        wr_color = 8'h55;
        count_clear(cyc, dn, tk, re, de);
        total++;
        if (cyc + 1 !== 19200) begin bad++; $display("FAIL req_clear_len got=%0d expected=19200", cyc + 1); end
        total++;
        if (re !== 1'b1 || de !== 1'b1 || dn !== 1) begin
            bad++;
            $display("FAIL req_clear_end ready_done=%b%b dones=%0d expected=11 1", re, de, dn);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        set_rd(0, 20, 20, 8'h00);
        set_rd(1, 24, 24, 8'h55);
        set_rd(2, 40, 80, 8'h00);
        set_rd(3, 639, 479, 8'h00);
        read_stream(4, "clear_overwrite_read");
    endtask

    task automatic test_frame_tick;
        int cyc, cnt, seen, e;
        next_x = '0;
        next_y = '0;
        repeat (4) @(negedge clk);
        cyc  = 0;
        cnt  = 0;
        seen = -1;
        for (int p = 0; p < 2; p++) begin
            for (int y = 0; y < 480; y += 16) begin
                for (int x = 0; x < 640; x += 16) begin
                    @(negedge clk);
                    if (frame_tick) begin cnt++; seen = cyc; end
                    next_x = 10'(x);
                    next_y = 10'(y);
                    if (p == 1 && x == 0 && y == 0) tick_q.push_back(cyc + 2);
                    cyc++;
                end
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (frame_tick) begin cnt++; seen = cyc; end
            cyc++;
        end
        total++;
        if (cnt !== 1) begin bad++; $display("FAIL tick_count got=%0d expected=1", cnt); end
        e = tick_q.pop_front();
        total++;
        if (seen !== e) begin bad++; $display("FAIL tick_cycle got=%0d expected=%0d", seen, e); end
    endtask

    task automatic test_reset_mid_clear;
        int cyc, dn, tk;
        logic re, de;
        logic r;
        do_write(6, 6, 8'h77, r);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (5000) @(negedge clk);
        #5;
        rst    = 1'b1;
        next_x = '0;
        next_y = '0;
        #1;
        total++;
        if ({color_out, wr_ready, wr_err, busy, clear_done, frame_tick} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset got=%h expected=0",
                     {color_out, wr_ready, wr_err, busy, clear_done, frame_tick});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_clear(cyc, dn, tk, re, de);
        total++;
        if (cyc !== 19200) begin bad++; $display("FAIL reclear_len got=%0d expected=19200", cyc); end
        total++;
        if (dn !== 1 || re !== 1'b1) begin
            bad++;
            $display("FAIL reclear_end dones=%0d ready=%b expected=1 1", dn, re);
        end
        total++;
        if (tk !== 0) begin bad++; $display("FAIL tick_after_reset got=%0d expected=0", tk); end
        set_rd(0, 24, 24, 8'h00);
        set_rd(1, 40, 80, 8'h00);
        read_stream(2, "reclear_read");
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_corners;
        test_bad_write;
        test_clear_with_write;
        test_frame_tick;
        test_reset_mid_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
